imm_operand_encoder: RTL and testbench
======================================

// Module: imm_operand_encoder
// PURPOSE
// - Inverse of the operand-2 value generator: takes a 32-bit constant and finds the 12-bit ARM
//   immediate shifter operand {rotate_imm[3:0], imm8[7:0]} such that value == imm8 ROR (2*rotate_imm).
// - Iterative search over the 16 rotations, CHECKS_PER_CYCLE rotations per clock.
// - Sits beside the instruction memory-init / self-test path; feeds encoded immediates to instruction words.
// PARAMETERS
// - CHECKS_PER_CYCLE  1  rotations evaluated per clock; legal values 1,2,4,8,16; other values are illegal.
// PORTS
// - clk            in   1   clock, rising edge
// - rst_n          in   1   asynchronous reset, active-low
// - start          in   1   request; sampled only while busy==0
// - value          in   32  constant to encode; latched on accepted start
// - busy           out  1   search in progress
// - done           out  1   one-cycle pulse: result valid
// - found          out  1   value is encodable (held)
// - inverted       out  1   encoding is of ~value (held; MVN form)
// - shift_operand  out  12  {rotate_imm, imm8} (held)
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset (any time, including mid-search): state IDLE; rot counter 0; pass 0.
//   busy, done, found and inverted all 0; shift_operand 12'h000.
// - FSM: IDLE -> SEARCH on start&&!busy (edge E0 latches value, clears found/inverted/shift_operand).
// - SEARCH -> DONE when a match is found or the last rotation of the final pass has been checked.
// - DONE lasts one cycle (done=1), then IDLE.
// - busy=1 in SEARCH and DONE. start while busy is ignored. Held results persist until the next accepted start.
// - Match test for rotation r: c = value ROL (2*r). Match iff c[31:8]==0; then imm8=c[7:0], rotate_imm=r.
// - In each SEARCH cycle, rotations r..r+N-1 (N=CHECKS_PER_CYCLE) are checked.
//   The lowest matching r wins (canonical encoding). Result is registered at that edge.
//   r advances by N per cycle. The 4-bit counter wraps from 15 to 0 only when moving to the next pass.
// - Latency: match at rotation k in pass 0 -> done high after edge E(floor(k/N)+1).
// - Not found (one pass) -> done after edge E(16/N), with found=0, shift_operand=0.
// - value==0: matches r=0 -> shift_operand 12'h000, found=1.
// - Match found on the last check of a pass -> found=1 (the found result takes priority over ending the pass).
// CONFIGURATION
// - Macro IMM_ENC_INVERT_EN, when defined:
//   - if pass 0 (on value) finds nothing, pass 1 repeats the search on ~value;
//   - a match in pass 1 sets inverted=1;
//   - total latency for not-found is 2*16/N edges.
// - Macro undefined: single pass only; inverted is tied 0; no pass-1 logic.
// TESTING
// - N=1, value 32'h000000FF -> done after E1, found=1, shift_operand 12'h0FF, inverted=0.
// - N=1, value 32'hFF000000 -> done after E5, found=1, shift_operand 12'h4FF.
// - N=1, value 32'hF000000F -> done after E3, shift_operand 12'h2FF.
// - N=1, value 32'h00000102 -> found=0, shift_operand 0.
//   - Without macro: done after E16.
//   - With IMM_ENC_INVERT_EN: done after E32.
// - N=1, IMM_ENC_INVERT_EN, value 32'hFFFFFF00 -> done after E17, found=1, inverted=1, shift_operand 12'h0FF.
//   - Same value without macro -> found=0 after E16.
// - N=4: 32'hFF000000 -> done after E2, shift_operand 12'h4FF.
// - N=16: any value -> done after E1.
// - Start pulsed during busy -> ignored, result unchanged.
// - rst_n low mid-search -> all outputs 0 immediately; a new start after release -> correct result from scratch.

Source files
------------

// File: rtl/imm_operand_encoder.sv
// ---------------------------------------------------------------------------
// imm_operand_encoder
//
// Purpose:
//   Finds the 12-bit ARM immediate shifter operand {rotate_imm, imm8} for a
//   32-bit constant, so that value == imm8 ROR (2*rotate_imm). The 16 possible
//   rotations are searched iteratively, CHECKS_PER_CYCLE rotations per clock.
//   The lowest matching rotation wins, which gives the canonical encoding.
//
// Parameters:
//   CHECKS_PER_CYCLE  rotations evaluated per clock (legal: 1, 2, 4, 8, 16)
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous reset, active-low
//   start          in   1   request, accepted only while busy is low
//   value          in   32  constant to encode, latched on an accepted start
//   busy           out  1   search in progress (SEARCH or DONE state)
//   done           out  1   one-cycle pulse, results are valid
//   found          out  1   value is encodable (held)
//   inverted       out  1   encoding is of ~value, MVN form (held)
//   shift_operand  out  12  {rotate_imm, imm8} (held)
//
// Configuration macro:
//   IMM_ENC_INVERT_EN  when defined, a failed search on value is followed by a
//                      second pass on ~value; a match there sets inverted.
//                      When undefined, only one pass exists and inverted is 0.
// ---------------------------------------------------------------------------
module imm_operand_encoder #(
    parameter int CHECKS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        inverted,
    output logic [11:0] shift_operand
);

    // Rotation step per cycle, and the first rotation of the final group of a
    // pass. With 16 checks per cycle both are 0: one cycle covers the pass.
    localparam logic [3:0] ROT_STEP = 4'(CHECKS_PER_CYCLE);
    localparam logic [3:0] ROT_LAST = 4'(16 - CHECKS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] value_q, value_d;
    logic        found_q, found_d;
    logic [11:0] shift_q, shift_d;

    logic [31:0] search_val;
    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic [3:0]  cand_rot;
    logic [31:0] cand;

    // Rotate left by sh bits, built from a doubled word so a shift of 0 is safe.
    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
        logic [63:0] w;
        w = {v, v} << sh;
        return w[63:32];
    endfunction

`ifdef IMM_ENC_INVERT_EN
    logic pass_q, pass_d;
    logic inverted_q, inverted_d;

    // Pass 1 searches the complement so the caller can emit an MVN instead.
    assign search_val = pass_q ? ~value_q : value_q;
    assign inverted   = inverted_q;
`else
    assign search_val = value_q;
    assign inverted   = 1'b0;
`endif

    // Undo the rotation for each candidate in this cycle's group; the value is
    // encodable at rotation r when the un-rotated word fits in the low byte.
    // Scanning upward and keeping the first hit selects the lowest rotation.
    always_comb begin
        hit      = 1'b0;
        hit_rot  = 4'd0;
        hit_imm  = 8'd0;
        cand_rot = 4'd0;
        cand     = 32'd0;
        for (int i = 0; i < CHECKS_PER_CYCLE; i++) begin
            cand_rot = rot_q + 4'(i);
            cand     = rol32(search_val, {cand_rot, 1'b0});
            if (!hit && (cand[31:8] == 24'd0)) begin
                hit     = 1'b1;
                hit_rot = cand_rot;
                hit_imm = cand[7:0];
            end
        end
    end

    // Next-state and held-result logic. A hit is checked before the end of a
    // pass, so a match on the very last rotation still reports found.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        found_d = found_q;
        shift_d = shift_q;
`ifdef IMM_ENC_INVERT_EN
        pass_d     = pass_q;
        inverted_d = inverted_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEARCH;
                    value_d = value;
                    rot_d   = 4'd0;
                    found_d = 1'b0;
                    shift_d = 12'h000;
`ifdef IMM_ENC_INVERT_EN
                    pass_d     = 1'b0;
                    inverted_d = 1'b0;
`endif
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_d = DONE;
                    rot_d   = 4'd0;
                    found_d = 1'b1;
                    shift_d = {hit_rot, hit_imm};
`ifdef IMM_ENC_INVERT_EN
                    inverted_d = pass_q;
`endif
                end else if (rot_q == ROT_LAST) begin
                    rot_d = 4'd0;
`ifdef IMM_ENC_INVERT_EN
                    if (!pass_q) begin
                        pass_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    rot_d = rot_q + ROT_STEP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset may arrive at any time, even mid-search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rot_q   <= 4'd0;
            value_q <= 32'd0;
            found_q <= 1'b0;
            shift_q <= 12'h000;
`ifdef IMM_ENC_INVERT_EN
            pass_q     <= 1'b0;
            inverted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            found_q <= found_d;
            shift_q <= shift_d;
`ifdef IMM_ENC_INVERT_EN
            pass_q     <= pass_d;
            inverted_q <= inverted_d;
`endif
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign found         = found_q;
    assign shift_operand = shift_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_operand_encoder
//
// Drives three encoder instances (1, 4 and 16 checks per cycle) with the same
// directed constants and compares latency, found, inverted and shift_operand
// against hand-computed values. Honours IMM_ENC_INVERT_EN for the expectations.
// ---------------------------------------------------------------------------
module tb_imm_operand_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic [2:0]  busyV;
    logic [2:0]  doneV;
    logic [2:0]  foundV;
    logic [2:0]  invV;
    logic [11:0] shiftV [3];

    int checks = 0;
    int errors = 0;

    int          lat    [3];
    int          pulses [3];
    logic        foundC [3];
    logic        invC   [3];
    logic [11:0] shiftC [3];
    logic [2:0]  busyE1;

    imm_operand_encoder #(.CHECKS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busyV[0]), .done(doneV[0]), .found(foundV[0]),
        .inverted(invV[0]), .shift_operand(shiftV[0])
    );

    imm_operand_encoder #(.CHECKS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busyV[1]), .done(doneV[1]), .found(foundV[1]),
        .inverted(invV[1]), .shift_operand(shiftV[1])
    );

    imm_operand_encoder #(.CHECKS_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busyV[2]), .done(doneV[2]), .found(foundV[2]),
        .inverted(invV[2]), .shift_operand(shiftV[2])
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launches one search on all instances and records, per instance, the
    // edge count at which done first appears plus the results at that moment.
    // Optionally pulses a second start (with a different value) while busy.
    task automatic applyStimulus(input logic [31:0] v, input bit glitch);
        for (int i = 0; i < 3; i++) begin
            lat[i]    = 0;
            pulses[i] = 0;
            foundC[i] = 1'b0;
            invC[i]   = 1'b0;
            shiftC[i] = 12'h000;
        end
        busyE1 = 3'b000;
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) busyE1 = busyV;
            for (int i = 0; i < 3; i++) begin
                if (doneV[i]) begin
                    pulses[i]++;
                    if (lat[i] == 0) begin
                        lat[i]    = k;
                        foundC[i] = foundV[i];
                        invC[i]   = invV[i];
                        shiftC[i] = shiftV[i];
                    end
                end
            end
            if (glitch && k == 1) begin
                start = 1'b1;
                value = 32'h000000FF;
            end
            if (k == 2) start = 1'b0;
        end
    endtask

    // One directed vector with its hand-computed results and per-instance latency
    task automatic runVector(input string name, input logic [31:0] v, input bit glitch,
                             input logic expFound, input logic [11:0] expShift,
                             input logic expInv, input int l1, input int l4, input int l16);
        int expLat [3];
        string n;
        expLat[0] = l1;
        expLat[1] = l4;
        expLat[2] = l16;
        applyStimulus(v, glitch);
        checkOutput({name, " busy after E1"}, 32'(busyE1), 32'b111);
        for (int i = 0; i < 3; i++) begin
            n = $sformatf("%s inst%0d", name, i);
            checkOutput({n, " latency"},   32'(lat[i]),    32'(expLat[i]));
            checkOutput({n, " pulses"},    32'(pulses[i]), 32'd1);
            checkOutput({n, " found"},     32'(foundC[i]), 32'(expFound));
            checkOutput({n, " inverted"},  32'(invC[i]),   32'(expInv));
            checkOutput({n, " shift"},     32'(shiftC[i]), 32'(expShift));
            checkOutput({n, " held shift"}, 32'(shiftV[i]), 32'(expShift));
        end
        checkOutput({name, " idle at end"}, 32'(busyV), 32'b000);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = 32'd0;
        #2;
        checkOutput("reset busy",  32'(busyV),  32'b000);
        checkOutput("reset done",  32'(doneV),  32'b000);
        checkOutput("reset found", 32'(foundV), 32'b000);
        checkOutput("reset inv",   32'(invV),   32'b000);
        checkOutput("reset shift", {shiftV[0][7:0], shiftV[1][11:0], shiftV[2][11:0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        runVector("v_000000FF", 32'h000000FF, 1'b0, 1'b1, 12'h0FF, 1'b0, 1, 1, 1);
        runVector("v_FF000000", 32'hFF000000, 1'b0, 1'b1, 12'h4FF, 1'b0, 5, 2, 1);
        runVector("v_F000000F", 32'hF000000F, 1'b0, 1'b1, 12'h2FF, 1'b0, 3, 1, 1);
        runVector("v_00000000", 32'h00000000, 1'b0, 1'b1, 12'h000, 1'b0, 1, 1, 1);
        runVector("v_000003FC", 32'h000003FC, 1'b0, 1'b1, 12'hFFF, 1'b0, 16, 4, 1);
        runVector("v_00000100", 32'h00000100, 1'b0, 1'b1, 12'hC01, 1'b0, 13, 4, 1);
`ifdef IMM_ENC_INVERT_EN
        runVector("v_00000102", 32'h00000102, 1'b0, 1'b0, 12'h000, 1'b0, 32, 8, 2);
        runVector("v_FFFFFF00", 32'hFFFFFF00, 1'b0, 1'b1, 12'h0FF, 1'b1, 17, 5, 2);
`else
        runVector("v_00000102", 32'h00000102, 1'b0, 1'b0, 12'h000, 1'b0, 16, 4, 1);
        runVector("v_FFFFFF00", 32'hFFFFFF00, 1'b0, 1'b0, 12'h000, 1'b0, 16, 4, 1);
`endif

        $display("[TB] start while busy");
        runVector("busy_start", 32'hFF000000, 1'b1, 1'b1, 12'h4FF, 1'b0, 5, 2, 1);

        $display("[TB] reset clears held results");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("idle reset found", 32'(foundV), 32'b000);
        checkOutput("idle reset shift", 32'(shiftV[0]), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset mid-search");
        @(negedge clk);
        value = 32'h00000102;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid busy before reset", 32'(busyV[1:0]), 32'b11);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy",  32'(busyV),  32'b000);
        checkOutput("mid reset done",  32'(doneV),  32'b000);
        checkOutput("mid reset found", 32'(foundV), 32'b000);
        @(negedge clk);
        rst_n = 1'b1;
        runVector("after_reset", 32'hF000000F, 1'b0, 1'b1, 12'h2FF, 1'b0, 3, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
